// File: rtl/spi_flash_responder.sv
// Serial-flash target: oversamples SPI/QSPI pads in ACLK, decodes a Winbond-style subset, serves byte memory + SR1/SR2.
// Latency: io_out/io_oe follow the pad CLOCK fall by at most 3 ACLK cycles (2 sync flops + 1 output register).
// Backpressure: none; the initiator's CLOCK paces every transfer and CS deassert ends it unconditionally.
//
// Ports: ACLK/ARESETn system clock and async active-low reset; CLOCK, CS, io_in[3:0] raw pads from the initiator;
// io_out/io_oe pad drive values and per-pin enables; status_reg1/status_reg2 live status registers;
// cmd_last opcode of the last transaction whose full opcode byte arrived.
module spi_flash_responder #(
  parameter int         MEM_DEPTH = 256,
  parameter logic [7:0] SR2_RESET = 8'h02
) (
  input  logic       ACLK,
  input  logic       ARESETn,
  input  logic       CLOCK,
  input  logic       CS,
  input  logic [3:0] io_in,
  output logic [3:0] io_out,
  output logic [3:0] io_oe,
  output logic [7:0] status_reg1,
  output logic [7:0] status_reg2,
  output logic [7:0] cmd_last
);
  localparam int AW = $clog2(MEM_DEPTH);
  // Page-program column wraps inside 256 bytes, or inside the whole memory when it is smaller.
  localparam int PW = (AW < 8) ? AW : 8;
  localparam logic [AW-1:0] PMASK = AW'((1 << PW) - 1);
  // Shift register only needs to hold the bits that survive into the byte or the memory index.
  localparam int SW = (AW - 1 > 7) ? AW - 1 : 7;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RD_DATA, S_WR_DATA, S_SR_OUT, S_IGNORE
  } state_t;

  state_t          state, state_nx;
  logic            clk_s1, clk_s2, clk_s3, cs_s1, cs_s2;
  logic [3:0]      io_s1, io_s2;
  logic            rise, fall, io0;
  logic [SW-1:0]   sh;
  logic [4:0]      bit_cnt;
  logic [2:0]      out_cnt;
  logic            out_started;
  logic [7:0]      opcode;
  logic            op_done;
  logic [AW-1:0]   addr;
  logic            wel;
  logic [5:0]      sr1_hi;
  logic [7:0]      sr2;
  logic [1:0]      wrsr_cnt;
  logic [5:0]      wrsr_b1;
  logic [7:0]      wrsr_b2;
  logic [7:0]      mem [MEM_DEPTH];
  logic [7:0]      byte_in, mem_rd, sr_sel;
  logic [AW-1:0]   addr_in, pp_next;
  logic            is_pp, quad, mem_we;
  logic            unused_io;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      clk_s1 <= 1'b0; clk_s2 <= 1'b0; clk_s3 <= 1'b0;
      cs_s1  <= 1'b1; cs_s2  <= 1'b1;
      io_s1  <= 4'h0; io_s2  <= 4'h0;
    end else begin
      clk_s1 <= CLOCK;  clk_s2 <= clk_s1; clk_s3 <= clk_s2;
      cs_s1  <= CS;     cs_s2  <= cs_s1;
      io_s1  <= io_in;  io_s2  <= io_s1;
    end
  end

  assign rise      = clk_s2 & ~clk_s3;
  assign fall      = ~clk_s2 & clk_s3;
  assign io0       = io_s2[0];
  assign unused_io = ^io_s2[3:1];   // upper pads are outputs only for this command set

  assign byte_in     = {sh[6:0], io0};
  assign addr_in     = {sh[AW-2:0], io0};
  assign mem_rd      = mem[addr];
  assign is_pp       = (opcode == 8'h02);
  assign quad        = (opcode == 8'h6B);
  assign status_reg1 = {sr1_hi, wel, 1'b0};
  assign status_reg2 = sr2;
  assign sr_sel      = (opcode == 8'h35) ? status_reg2 : status_reg1;
  assign pp_next     = (addr & ~PMASK) | ((addr + AW'(1)) & PMASK);
  assign mem_we      = !cs_s2 && rise && (state == S_WR_DATA) && (bit_cnt == 5'd7) && is_pp;

  // FSM: state register
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= S_IDLE;
    else          state <= state_nx;
  end

  // FSM: next state; a synced CS high overrides any clock edge in the same cycle
  always_comb begin
    state_nx = state;
    if (cs_s2) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: state_nx = S_CMD;
        S_CMD: if (rise && bit_cnt == 5'd7) begin
          case (byte_in)
            8'h05, 8'h35:        state_nx = S_SR_OUT;
            8'h01:               state_nx = S_WR_DATA;
            8'h03, 8'h6B, 8'h02: state_nx = S_ADDR;
            default:             state_nx = S_IGNORE;
          endcase
        end
        S_ADDR: if (rise && bit_cnt == 5'd23) begin
          if (opcode == 8'h03)      state_nx = S_RD_DATA;
          else if (quad)            state_nx = sr2[1] ? S_DUMMY : S_IGNORE;
          else                      state_nx = wel ? S_WR_DATA : S_IGNORE;
        end
        S_DUMMY: if (rise && bit_cnt == 5'd7) state_nx = S_RD_DATA;
        default: ;
      endcase
    end
  end

  // FSM: outputs; enables rise together with the first driven bit so IO0 is never contended early
  always_comb begin
    io_oe = 4'b0000;
    case (state)
      S_RD_DATA: if (out_started) io_oe = quad ? 4'b1111 : 4'b0010;
      S_SR_OUT:  if (out_started) io_oe = 4'b0010;
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      sh <= '0; bit_cnt <= 5'd0; out_cnt <= 3'd0; out_started <= 1'b0; io_out <= 4'h0;
      opcode <= 8'h00; op_done <= 1'b0; addr <= '0;
      wel <= 1'b0; sr1_hi <= 6'h00; sr2 <= SR2_RESET; cmd_last <= 8'h00;
      wrsr_cnt <= 2'd0; wrsr_b1 <= 6'h00; wrsr_b2 <= 8'h00;
    end else if (cs_s2) begin
      bit_cnt <= 5'd0; out_cnt <= 3'd0; out_started <= 1'b0; io_out <= 4'h0;
      wrsr_cnt <= 2'd0; op_done <= 1'b0;
      // Deferred side effects commit once, on the first synced-high cycle.
      if (op_done) begin
        cmd_last <= opcode;
        case (opcode)
          8'h06: wel <= 1'b1;
          8'h04, 8'h02: wel <= 1'b0;
          8'h01: begin
            if (wel) begin
              if (wrsr_cnt != 2'd0) sr1_hi <= wrsr_b1;
              if (wrsr_cnt == 2'd2) sr2 <= wrsr_b2;
            end
            wel <= 1'b0;
          end
          default: ;
        endcase
      end
    end else begin
      if (rise) begin
        sh <= {sh[SW-2:0], io0};
        case (state)
          S_CMD: begin
            if (bit_cnt == 5'd7) begin
              bit_cnt <= 5'd0; opcode <= byte_in; op_done <= 1'b1;
            end else bit_cnt <= bit_cnt + 5'd1;
          end
          S_ADDR: begin
            if (bit_cnt == 5'd23) begin
              bit_cnt <= 5'd0; addr <= addr_in;
            end else bit_cnt <= bit_cnt + 5'd1;
          end
          S_DUMMY: bit_cnt <= (bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
          S_WR_DATA: begin
            bit_cnt <= (bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              if (is_pp) addr <= pp_next;
              else if (wrsr_cnt != 2'd2) begin
                if (wrsr_cnt == 2'd0) wrsr_b1 <= byte_in[7:2];
                else                  wrsr_b2 <= byte_in;
                wrsr_cnt <= wrsr_cnt + 2'd1;
              end
            end
          end
          default: ;
        endcase
      end
      if (fall) begin
        if (state == S_RD_DATA) begin
          out_started <= 1'b1;
          out_cnt     <= out_cnt + 3'd1;
          if (quad) begin
            io_out <= out_cnt[0] ? mem_rd[3:0] : mem_rd[7:4];
            if (out_cnt[0]) addr <= addr + AW'(1);
          end else begin
            io_out <= {2'b00, mem_rd[3'd7 - out_cnt], 1'b0};
            if (out_cnt == 3'd7) addr <= addr + AW'(1);
          end
        end else if (state == S_SR_OUT) begin
          out_started <= 1'b1;
          out_cnt     <= out_cnt + 3'd1;
          io_out      <= {2'b00, sr_sel[3'd7 - out_cnt], 1'b0};
        end
      end
    end
  end

  // Program can only clear bits, so each completed byte ANDs into the cell.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= 8'hFF;
    end else if (mem_we) begin
      mem[addr] <= mem[addr] & byte_in;
    end
  end
endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: drives the pads as a mode-0 initiator (100-unit SPI period, 10x ACLK),
// compares against constant vectors, a flash behaviour model under random traffic, and reset/abort sequences.
module tb_spi_flash_responder;
  localparam int DEPTH = 256;

  logic       ACLK    = 1'b0;
  logic       ARESETn = 1'b0;
  logic       CLOCK   = 1'b0;
  logic       CS      = 1'b1;
  logic [3:0] io_in   = 4'h0;
  logic [3:0] io_out, io_oe;
  logic [7:0] sr1, sr2, cmd_last;

  spi_flash_responder #(.MEM_DEPTH(DEPTH), .SR2_RESET(8'h02)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .CLOCK(CLOCK), .CS(CS), .io_in(io_in),
    .io_out(io_out), .io_oe(io_oe), .status_reg1(sr1), .status_reg2(sr2), .cmd_last(cmd_last)
  );

  initial forever #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  // Behavioural flash model
  logic [7:0] m_mem [DEPTH];
  logic [5:0] m_sr1hi;
  logic       m_wel;
  logic [7:0] m_sr2, m_cmd;

  typedef struct packed {
    logic [63:0] tx;   // bytes right-aligned, first byte most significant
    logic [7:0]  ntx;
    logic [7:0]  nrd;
    logic [3:0]  oe;   // enable pattern expected on every read cycle
    logic [31:0] ex;   // read bytes right-aligned
    logic [7:0]  sr1, sr2, cmd;
  } vec_t;

  vec_t vecs [24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] txb(input logic [63:0] tx, input int ntx, input int i);
    return tx[8*(ntx-1-i) +: 8];
  endfunction

  function automatic vec_t mkv(input logic [63:0] tx, input int ntx, input int nrd, input logic [3:0] oe,
                               input logic [31:0] ex, input logic [7:0] s1, input logic [7:0] s2,
                               input logic [7:0] c);
    vec_t v;
    v.tx = tx; v.ntx = 8'(ntx); v.nrd = 8'(nrd); v.oe = oe; v.ex = ex;
    v.sr1 = s1; v.sr2 = s2; v.cmd = c;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'hFF;
    m_sr1hi = 6'h00; m_wel = 1'b0; m_sr2 = 8'h02; m_cmd = 8'h00;
  endtask

  task automatic model_txn(input logic [63:0] tx, input int ntx, input int nrd,
                           output logic [31:0] ex, output logic [3:0] eoe);
    logic [7:0] op, b, s1;
    int a;
    op = txb(tx, ntx, 0);
    a  = 0;
    if (ntx >= 4) a = int'({txb(tx, ntx, 1), txb(tx, ntx, 2), txb(tx, ntx, 3)}) % DEPTH;
    s1 = {m_sr1hi, m_wel, 1'b0};
    ex = 0; eoe = 4'h0;
    case (op)
      8'h05, 8'h35: begin
        eoe = 4'b0010;
        for (int i = 0; i < nrd; i++) ex = (ex << 8) | 32'((op == 8'h05) ? s1 : m_sr2);
      end
      8'h03, 8'h6B: begin
        if (op == 8'h03 || m_sr2[1]) begin
          eoe = (op == 8'h03) ? 4'b0010 : 4'b1111;
          for (int i = 0; i < nrd; i++) ex = (ex << 8) | 32'(m_mem[(a + i) % DEPTH]);
        end
      end
      8'h02: begin
        if (m_wel)
          for (int i = 4; i < ntx; i++) begin
            b = txb(tx, ntx, i);
            m_mem[(a + i - 4) % DEPTH] = m_mem[(a + i - 4) % DEPTH] & b;
          end
        m_wel = 1'b0;
      end
      8'h01: begin
        if (m_wel) begin
          if (ntx >= 2) begin b = txb(tx, ntx, 1); m_sr1hi = b[7:2]; end
          if (ntx >= 3) m_sr2 = txb(tx, ntx, 2);
        end
        m_wel = 1'b0;
      end
      8'h06: m_wel = 1'b1;
      8'h04: m_wel = 1'b0;
      default: ;
    endcase
    m_cmd = op;
  endtask

  // One SPI clock: value seen just before the rise is what the initiator samples.
  task automatic spi_cycle(input logic din, output logic [3:0] dout, output logic [3:0] oe);
    io_in = {3'b000, din};
    #50;
    dout = io_out; oe = io_oe;
    CLOCK = 1'b1;
    #50;
    CLOCK = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [3:0] d, oe;
    for (int k = 7; k >= 0; k--) spi_cycle(b[k], d, oe);
  endtask

  task automatic do_txn(input logic [63:0] tx, input int ntx, input int nrd, input int part,
                        output logic [31:0] rx, output logic [3:0] oe_or, output logic [3:0] oe_and);
    logic [3:0] d, oe;
    logic [7:0] op, rb;
    op = txb(tx, ntx, 0);
    rx = 0; oe_or = 4'h0; oe_and = 4'hF;
    CS = 1'b0;
    for (int i = 0; i < ntx; i++) send_byte(txb(tx, ntx, i));
    for (int k = 0; k < part; k++) spi_cycle(1'b0, d, oe);
    if (op == 8'h6B && ntx == 4) for (int k = 0; k < 8; k++) spi_cycle(1'b0, d, oe);
    for (int r = 0; r < nrd; r++) begin
      rb = 8'h00;
      if (op == 8'h6B) begin
        for (int k = 0; k < 2; k++) begin
          spi_cycle(1'b0, d, oe); rb = {rb[3:0], d}; oe_or |= oe; oe_and &= oe;
        end
      end else begin
        for (int k = 0; k < 8; k++) begin
          spi_cycle(1'b0, d, oe); rb = {rb[6:0], d[1]}; oe_or |= oe; oe_and &= oe;
        end
      end
      rx = {rx[23:0], rb};
    end
    #50; CS = 1'b1;
    #100;
  endtask

  task automatic run_model(input string nm, input logic [63:0] tx, input int ntx, input int nrd, input int part);
    logic [31:0] ex, rx;
    logic [3:0]  eoe, oor, oand;
    model_txn(tx, ntx, nrd, ex, eoe);
    do_txn(tx, ntx, nrd, part, rx, oor, oand);
    if (nrd > 0) begin
      if (eoe != 4'h0) check({nm, " rx"}, rx, ex);
      check({nm, " oe_or"}, 32'(oor), 32'(eoe));
      check({nm, " oe_and"}, 32'(oand), 32'(eoe));
    end
    check({nm, " sr1"}, 32'(sr1), 32'({m_sr1hi, m_wel, 1'b0}));
    check({nm, " sr2"}, 32'(sr2), 32'(m_sr2));
    check({nm, " cmd"}, 32'(cmd_last), 32'(m_cmd));
  endtask

  initial begin
    logic [31:0] ex, rx;
    logic [3:0]  eoe, oor, oand, d, oe;
    logic [63:0] tx;
    logic [7:0]  op, lo;
    int          ntx, nrd;
    logic [7:0]  ops [10];

    vecs[0]  = mkv(64'h05,             1, 1, 4'b0010, 32'h00,     8'h00, 8'h02, 8'h05);
    vecs[1]  = mkv(64'h35,             1, 1, 4'b0010, 32'h02,     8'h00, 8'h02, 8'h35);
    vecs[2]  = mkv(64'h06,             1, 0, 4'b0000, 32'h0,      8'h02, 8'h02, 8'h06);
    vecs[3]  = mkv(64'h05,             1, 2, 4'b0010, 32'h0202,   8'h02, 8'h02, 8'h05);
    vecs[4]  = mkv(64'h02000010A53C,   6, 0, 4'b0000, 32'h0,      8'h00, 8'h02, 8'h02);
    vecs[5]  = mkv(64'h03000010,       4, 3, 4'b0010, 32'hA53CFF, 8'h00, 8'h02, 8'h03);
    vecs[6]  = mkv(64'h0200002000,     5, 0, 4'b0000, 32'h0,      8'h00, 8'h02, 8'h02);
    vecs[7]  = mkv(64'h03000020,       4, 1, 4'b0010, 32'hFF,     8'h00, 8'h02, 8'h03);
    vecs[8]  = mkv(64'h06,             1, 0, 4'b0000, 32'h0,      8'h02, 8'h02, 8'h06);
    vecs[9]  = mkv(64'h02000030F0,     5, 0, 4'b0000, 32'h0,      8'h00, 8'h02, 8'h02);
    vecs[10] = mkv(64'h06,             1, 0, 4'b0000, 32'h0,      8'h02, 8'h02, 8'h06);
    vecs[11] = mkv(64'h020000300F,     5, 0, 4'b0000, 32'h0,      8'h00, 8'h02, 8'h02);
    vecs[12] = mkv(64'h03000030,       4, 1, 4'b0010, 32'h00,     8'h00, 8'h02, 8'h03);
    vecs[13] = mkv(64'h06,             1, 0, 4'b0000, 32'h0,      8'h02, 8'h02, 8'h06);
    vecs[14] = mkv(64'h020000FEA55AC3, 7, 0, 4'b0000, 32'h0,      8'h00, 8'h02, 8'h02);
    vecs[15] = mkv(64'h030000FE,       4, 3, 4'b0010, 32'hA55AC3, 8'h00, 8'h02, 8'h03);
    vecs[16] = mkv(64'h6B0000FE,       4, 3, 4'b1111, 32'hA55AC3, 8'h00, 8'h02, 8'h6B);
    vecs[17] = mkv(64'h06,             1, 0, 4'b0000, 32'h0,      8'h02, 8'h02, 8'h06);
    vecs[18] = mkv(64'h010000,         3, 0, 4'b0000, 32'h0,      8'h00, 8'h00, 8'h01);
    vecs[19] = mkv(64'h6B000000,       4, 2, 4'b0000, 32'h0,      8'h00, 8'h00, 8'h6B);
    vecs[20] = mkv(64'h9F,             1, 1, 4'b0000, 32'h0,      8'h00, 8'h00, 8'h9F);
    vecs[21] = mkv(64'h06,             1, 0, 4'b0000, 32'h0,      8'h02, 8'h00, 8'h06);
    vecs[22] = mkv(64'h010002,         3, 0, 4'b0000, 32'h0,      8'h00, 8'h02, 8'h01);
    vecs[23] = mkv(64'h35,             1, 1, 4'b0010, 32'h02,     8'h00, 8'h02, 8'h35);

    model_reset();
    #40;
    check("reset io_oe", 32'(io_oe), 32'h0);
    check("reset io_out", 32'(io_out), 32'h0);
    ARESETn = 1'b1;
    #40;
    check("post-reset sr1", 32'(sr1), 32'h00);
    check("post-reset sr2", 32'(sr2), 32'h02);
    check("post-reset cmd", 32'(cmd_last), 32'h00);

    // Constant vectors; the model follows along so later phases start from the same state.
    for (int k = 0; k < 24; k++) begin
      model_txn(vecs[k].tx, int'(vecs[k].ntx), int'(vecs[k].nrd), ex, eoe);
      do_txn(vecs[k].tx, int'(vecs[k].ntx), int'(vecs[k].nrd), 0, rx, oor, oand);
      if (vecs[k].nrd != 0) begin
        if (vecs[k].oe != 4'h0) check($sformatf("v%0d rx", k), rx, vecs[k].ex);
        check($sformatf("v%0d oe_or", k), 32'(oor), 32'(vecs[k].oe));
        check($sformatf("v%0d oe_and", k), 32'(oand), 32'(vecs[k].oe));
      end
      check($sformatf("v%0d sr1", k), 32'(sr1), 32'(vecs[k].sr1));
      check($sformatf("v%0d sr2", k), 32'(sr2), 32'(vecs[k].sr2));
      check($sformatf("v%0d cmd", k), 32'(cmd_last), 32'(vecs[k].cmd));
      check($sformatf("v%0d idle oe", k), 32'(io_oe), 32'h0);
    end

    // PP data byte cut after 5 bits: nothing written, WEL still cleared, opcode recorded.
    run_model("pp wren", 64'h06, 1, 0, 0);
    run_model("pp cut", 64'h02000040, 4, 0, 5);
    check("pp cut sr1", 32'(sr1), 32'h00);
    check("pp cut cmd", 32'(cmd_last), 32'h02);
    run_model("pp cut rd", 64'h03000040, 4, 1, 0);

    // Random traffic against the model, addresses clustered around the 255->0 wrap.
    ops = '{8'h05, 8'h35, 8'h06, 8'h06, 8'h04, 8'h03, 8'h6B, 8'h02, 8'h01, 8'h9F};
    for (int n = 0; n < 24; n++) begin
      op  = ops[$urandom_range(0, 9)];
      lo  = 8'($urandom_range(0, 11)) + 8'd250;
      tx  = 64'(op); ntx = 1; nrd = 0;
      case (op)
        8'h05, 8'h35: nrd = $urandom_range(1, 3);
        8'h03, 8'h6B: begin
          tx = {32'h0, op, 8'($urandom), 8'($urandom), lo}; ntx = 4; nrd = $urandom_range(1, 4);
        end
        8'h02: begin
          tx = {32'h0, op, 8'($urandom), 8'($urandom), lo}; ntx = 4;
          for (int j = $urandom_range(1, 4); j > 0; j--) begin tx = (tx << 8) | 64'(8'($urandom)); ntx++; end
        end
        8'h01: begin tx = {40'h0, op, 8'($urandom), 8'($urandom)}; ntx = 3; end
        8'h9F: nrd = 1;
        default: ;
      endcase
      run_model($sformatf("rnd%0d op%h", n, op), tx, ntx, nrd, 0);
    end

    // Reset pulsed in the middle of a READ data phase.
    run_model("rst wren", 64'h06, 1, 0, 0);
    run_model("rst pp", 64'h0200001077, 5, 0, 0);
    CS = 1'b0;
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
    for (int k = 0; k < 3; k++) spi_cycle(1'b0, d, oe);
    check("mid-read oe", 32'(oe), 32'b0010);
    ARESETn = 1'b0;
    CS = 1'b1;
    #1;
    check("rst oe", 32'(io_oe), 32'h0);
    check("rst sr1", 32'(sr1), 32'h00);
    check("rst cmd", 32'(cmd_last), 32'h00);
    #29;
    ARESETn = 1'b1;
    #60;
    model_reset();
    check("rst sr2", 32'(sr2), 32'h02);
    run_model("rst rd10", 64'h03000010, 4, 2, 0);
    run_model("rst rdFE", 64'h030000FE, 4, 3, 0);
    do_txn(64'h03000030, 4, 1, 0, rx, oor, oand);
    check("rst mem30", rx, 32'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- Synthesizable SPI/QSPI serial-flash responder: the target end of the serial-flash link driven by the team's spi initiator (IO0-IO3, CS, CLOCK).
- Oversamples the link in the ACLK domain, decodes a Winbond-style command subset, and serves a small on-chip byte memory plus SR1/SR2.
- Used for on-FPGA loopback on GPIO and as an RTL bench model, so the initiator can be tested without a physical flash.

Parameters:
- MEM_DEPTH, 256, bytes of backing memory; power of two, 16..4096.
- SR2_RESET, 8'h02, SR2 value after reset (bit1 = QE, quad enable).

Ports:
- ACLK  in  1  system clock; must run at least 8x the CLOCK frequency.
- ARESETn  in  1  asynchronous active-low reset.
- CLOCK  in  1  serial clock from the initiator, mode 0 (idles low).
- CS  in  1  chip select, active low.
- io_in  in  4  IO3..IO0 pad inputs.
- io_out  out  4  IO3..IO0 pad output values.
- io_oe  out  4  per-pin output enable; 1 = drive.
- status_reg1  out  8  current SR1 (bit1 = WEL, bit0 = BUSY, always 0).
- status_reg2  out  8  current SR2.
- cmd_last  out  8  opcode of the most recently completed transaction.

Behaviour:
- Reset: io_out=0, io_oe=0, SR1=8'h00, SR2=SR2_RESET, cmd_last=8'h00, every memory byte=8'hFF, FSM=IDLE.
- Input sync: CLOCK, CS and io_in each pass through two ACLK flops. Edge detect runs on the synchronized CLOCK.
  - Rising edge (rise) = sample.
  - Falling edge (fall) = shift out.
- Output latency: io_out/io_oe update no later than 3 ACLK cycles after the pad falling edge.
- CS high (synced), from any state: FSM -> IDLE, io_oe=0, bit counters cleared, any partial byte discarded. A completed write opcode commits its side effects here, at the CS deassert.
- FSM states: IDLE, CMD, ADDR, DUMMY, RD_DATA, WR_DATA, SR_OUT, IGNORE.
  - IDLE -> CMD on CS falling.
  - CMD: shifts 8 bits MSB-first from io_in[0] on rise. On the 8th bit, decode:
    - 06 WREN: set WEL at CS rise.
    - 04 WRDI: clear WEL at CS rise.
    - 05 RDSR1 -> SR_OUT with SR1; 35 RDSR2 -> SR_OUT with SR2.
    - 01 WRSR -> WR_DATA. Byte 1 -> SR1[7:2], byte 2 -> SR2. Ignored if WEL=0. Clears WEL at CS rise.
    - 03 READ -> ADDR.
    - 6B QUAD OUTPUT READ -> ADDR. If QE=0, go to IGNORE after ADDR instead.
    - 02 PAGE PROGRAM -> ADDR, then WR_DATA. If WEL=0, go to IGNORE after ADDR.
    - Any other opcode -> IGNORE.
  - ADDR: 24 bits MSB-first on io_in[0]. The memory index is addr[log2(MEM_DEPTH)-1:0]; upper bits are ignored.
  - DUMMY (6B only): 8 CLOCK cycles with io_oe=0, then RD_DATA.
  - RD_DATA (03): io_oe=4'b0010, io_out[1]=mem bit MSB-first. The MSB is driven on the fall after the last address rise, or after the last dummy rise for 6B.
  - RD_DATA (6B): io_oe=4'b1111, 4 bits per fall, high nibble first.
  - Address post-increments per byte and wraps MEM_DEPTH-1 -> 0. Continues until CS rises.
  - SR_OUT: same 1-bit output scheme as READ. Repeats the selected register indefinitely; reflects live values.
  - WR_DATA (02): each complete byte is written immediately as mem[a] <= mem[a] & byte (program can only clear bits). The column address wraps inside the 256-byte page: the upper address bits are held and the low 8 bits wrap 255 -> 0; if MEM_DEPTH < 256, wrap at MEM_DEPTH. WEL clears at CS rise.
  - IGNORE: io_oe=0 until CS rises; no state change.
- Simultaneous edges: CS rise takes priority over a CLOCK edge seen in the same ACLK cycle. A byte whose 8th bit lands in that same cycle is discarded.
- ARESETn low mid-transaction: immediate return to the reset values, including memory.
- cmd_last updates at CS rise, only if the full 8-bit opcode was received.

Test Plan:
- Reset, then 05 -> IO1 returns 8'h00; 35 -> IO1 returns 8'h02; io_oe=0 while CS is high.
- 06, CS high; 05 -> 8'h02. Then 02 000010 A5 3C -> WEL returns 0. Then 03 000010 -> A5, 3C, FF.
- 02 without WREN -> memory unchanged. PP of 0F over an existing F0 -> reads 00. PP at 0000FE with 3 bytes -> bytes land at FE, FF, 00.
- 6B 0000FE, 8 dummy clocks -> nibbles on IO3..0 give A5-style data for FE, FF, then wrap to 00. With SR2=00 (via WREN + WRSR 00 00), 6B -> io_oe stays 0.
- CS raised after 5 bits of a PP data byte -> byte not written, WEL cleared, cmd_last=02. Opcode 9F -> IGNORE, io_oe=0, no state change.
- ARESETn pulsed low during RD_DATA -> io_oe=0 within 1 cycle, memory reads all FF, SR1=00.
